// File: rtl/inst_loader.sv
// Boot-time instruction loader: assembles big-endian 16-bit words from a byte
// stream, writes them to the instruction store, then verifies an XOR checksum.
module inst_loader #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              busy,
    output logic              cpu_en,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_CHK, S_DONE, S_FAIL
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] count_reg;
    logic [7:0]        hi_reg;
    logic [7:0]        chk_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [WORD_W-1:0] wr_data_reg;
    logic              accept;
    logic              start;

    // All outputs are decoded from state or registered; no input-to-output paths.
    assign byte_ready = (state_reg == S_COUNT) || (state_reg == S_HI) ||
                        (state_reg == S_LO)    || (state_reg == S_CHK);
    assign busy       = byte_ready || (state_reg == S_WRITE);
    assign wr_en      = (state_reg == S_WRITE);
    assign cpu_en     = (state_reg == S_DONE);
    assign err        = (state_reg == S_FAIL);
    assign wr_addr    = wr_addr_reg;
    assign wr_data    = wr_data_reg;

    assign accept = byte_valid && byte_ready;
    assign start  = load_start && !busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE, S_FAIL: if (load_start) state_next = S_COUNT;
            S_COUNT:                if (byte_valid) state_next = S_HI;
            S_HI:                   if (byte_valid) state_next = S_LO;
            S_LO:                   if (byte_valid) state_next = S_WRITE;
            // A count of 1 here is the last word; a loaded count of 0 means a full image.
            S_WRITE:                state_next = (count_reg == ADDR_W'(1)) ? S_CHK : S_HI;
            S_CHK: begin
                if (byte_valid) begin
                    state_next = (chk_reg == byte_in) ? S_DONE : S_FAIL;
                end
            end
            default:                state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_reg    <= '0;
            count_reg   <= '0;
            hi_reg      <= '0;
            chk_reg     <= '0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            if (start) begin
                addr_reg <= '0;
                chk_reg  <= '0;
            end
            if (accept && state_reg == S_COUNT) begin
                count_reg <= ADDR_W'(byte_in);
            end
            if (accept && state_reg == S_HI) begin
                hi_reg  <= byte_in;
                chk_reg <= chk_reg ^ byte_in;
            end
            // Capture the write address/data here so they are stable during WRITE.
            if (accept && state_reg == S_LO) begin
                wr_addr_reg <= addr_reg;
                wr_data_reg <= WORD_W'({hi_reg, byte_in});
                chk_reg     <= chk_reg ^ byte_in;
            end
            if (state_reg == S_WRITE) begin
                addr_reg  <= addr_reg + ADDR_W'(1);
                count_reg <= count_reg - ADDR_W'(1);
            end
        end
    end

endmodule
